router_sync: RTL and testbench



---
 rtl/router_pkg.sv | 16 +
 rtl/router_sync_timer.sv | 40 ++++
 rtl/router_sync.sv | 79 +++++++
 tb/tb_router_sync.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared constants for the router output-side synchroniser.
package router_pkg;
  localparam int NUM_PORTS = 3;
  localparam int ADDR_W = 2;
  localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;
  localparam int DEFAULT_TIMEOUT = 30;

  function automatic logic [7:0] popcount(input logic [NUM_PORTS-1:0] v);
    logic [7:0] n;
    n = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      n = n + 8'(v[i]);
    end
    return n;
  endfunction
endpackage

// File: rtl/router_sync_timer.sv
// Per-port watchdog: one-cycle soft_reset after TIMEOUT unread cycles of valid data.
module router_sync_timer #(
  parameter int TIMEOUT = router_pkg::DEFAULT_TIMEOUT
) (
  input  logic clock,
  input  logic resetn,
  input  logic vld,
  input  logic rd,
  output logic soft_reset
);
  localparam int CNT_W = $clog2(TIMEOUT);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;

  always_comb begin
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    if (!vld || rd) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
      pulse_d = 1'b1;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign soft_reset = pulse_q;
endmodule

// File: rtl/router_sync.sv
// Address latch, write steering, valid flags and per-port timeouts for the router FIFOs.
// Optional drop counter enabled by defining ROUTER_SYNC_DROP_CNT_EN.
module router_sync
  import router_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 detect_add,
  input  logic [ADDR_W-1:0]    data_in,
  input  logic                 write_enb_reg,
  input  logic [NUM_PORTS-1:0] empty,
  input  logic [NUM_PORTS-1:0] full,
  input  logic [NUM_PORTS-1:0] read_enb,
  output logic [NUM_PORTS-1:0] write_enb,
  output logic                 fifo_full,
  output logic [NUM_PORTS-1:0] vld_out,
`ifdef ROUTER_SYNC_DROP_CNT_EN
  output logic [7:0]           drop_count,
`endif
  output logic [NUM_PORTS-1:0] soft_reset
);
  logic [ADDR_W-1:0] addr_q, addr_d;

  always_comb begin
    addr_d = detect_add ? data_in : addr_q;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      addr_q <= ADDR_INVALID;
    end else begin
      addr_q <= addr_d;
    end
  end

  // Decode from the registered address only, so a same-cycle header goes to the old port.
  always_comb begin
    write_enb = '0;
    fifo_full = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      write_enb[i] = write_enb_reg && (addr_q == ADDR_W'(i));
      fifo_full    = fifo_full | (full[i] && (addr_q == ADDR_W'(i)));
    end
  end

  assign vld_out = ~empty;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_timer
    router_sync_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clock      (clock),
      .resetn     (resetn),
      .vld        (vld_out[g]),
      .rd         (read_enb[g]),
      .soft_reset (soft_reset[g])
    );
  end

`ifdef ROUTER_SYNC_DROP_CNT_EN
  logic [7:0] drop_q, drop_d;
  logic [8:0] drop_sum;

  always_comb begin
    drop_sum = {1'b0, drop_q} + {1'b0, popcount(soft_reset)};
    drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      drop_q <= '0;
    end else begin
      drop_q <= drop_d;
    end
  end

  assign drop_count = drop_q;
`endif
endmodule

// File: tb/tb_router_sync.sv
// Self-checking bench for router_sync: vector table for steering, scoreboard for timeouts.
module tb_router_sync;
  import router_pkg::*;

  typedef struct {
    logic       det;
    logic [1:0] din;
    logic       wer;
    logic [2:0] fullIn;
    logic [2:0] emptyIn;
    logic [2:0] expWe;
    logic       expFf;
    logic [2:0] expVld;
  } vec_t;

  typedef struct {
    int         cyc;
    logic [2:0] mask;
  } pulse_t;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       detectAdd = 1'b0;
  logic [1:0] dataIn = 2'b00;
  logic       writeEnbReg = 1'b0;
  logic [2:0] emptyIn = 3'b111;
  logic [2:0] fullIn = 3'b000;
  logic [2:0] readEnb = 3'b000;
  logic [2:0] writeEnb;
  logic       fifoFull;
  logic [2:0] vldOut;
  logic [2:0] softReset;
`ifdef ROUTER_SYNC_DROP_CNT_EN
  logic [7:0] dropCount;
`endif

  int     errors = 0;
  int     checks = 0;
  int     cyc = 0;
  int     dropExp = 0;
  logic   monEn = 1'b0;
  vec_t   vecs[10];
  pulse_t sbQ[$];

  router_sync dut (
    .clock         (clock),
    .resetn        (resetn),
    .detect_add    (detectAdd),
    .data_in       (dataIn),
    .write_enb_reg (writeEnbReg),
    .empty         (emptyIn),
    .full          (fullIn),
    .read_enb      (readEnb),
    .write_enb     (writeEnb),
    .fifo_full     (fifoFull),
    .vld_out       (vldOut),
`ifdef ROUTER_SYNC_DROP_CNT_EN
    .drop_count    (dropCount),
`endif
    .soft_reset    (softReset)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    detectAdd   = v.det;
    dataIn      = v.din;
    writeEnbReg = v.wer;
    fullIn      = v.fullIn;
    emptyIn     = v.emptyIn;
  endtask

  task automatic expectPulse(input int atCyc, input logic [2:0] mask);
    pulse_t p;
    p.cyc  = atCyc;
    p.mask = mask;
    sbQ.push_back(p);
    dropExp = dropExp + int'(popcount(mask));
  endtask

  // Every cycle soft_reset must be zero unless the scoreboard predicts a pulse now.
  always @(negedge clock) begin
    if (monEn) begin
      logic [2:0] exp;
      exp = 3'b000;
      if (sbQ.size() > 0 && sbQ[0].cyc == cyc) begin
        exp = sbQ[0].mask;
        void'(sbQ.pop_front());
      end
      checkOutput("soft_reset", {5'b0, softReset}, {5'b0, exp});
    end
  end

  initial begin
    int k;

    // det din wer full empty | we ff vld  (expectations use the address held before the edge)
    vecs[0] = '{1'b0, 2'b00, 1'b1, 3'b111, 3'b111, 3'b000, 1'b0, 3'b000};
    vecs[1] = '{1'b1, 2'b11, 1'b1, 3'b111, 3'b110, 3'b000, 1'b0, 3'b001};
    vecs[2] = '{1'b1, 2'b01, 1'b0, 3'b010, 3'b101, 3'b000, 1'b0, 3'b010};
    vecs[3] = '{1'b0, 2'b00, 1'b1, 3'b010, 3'b111, 3'b010, 1'b1, 3'b000};
    vecs[4] = '{1'b0, 2'b00, 1'b1, 3'b101, 3'b011, 3'b010, 1'b0, 3'b100};
    vecs[5] = '{1'b1, 2'b00, 1'b0, 3'b001, 3'b111, 3'b000, 1'b0, 3'b000};
    vecs[6] = '{1'b1, 2'b10, 1'b1, 3'b001, 3'b111, 3'b001, 1'b1, 3'b000};
    vecs[7] = '{1'b0, 2'b00, 1'b1, 3'b100, 3'b111, 3'b100, 1'b1, 3'b000};
    vecs[8] = '{1'b1, 2'b11, 1'b1, 3'b100, 3'b111, 3'b100, 1'b1, 3'b000};
    vecs[9] = '{1'b0, 2'b00, 1'b1, 3'b111, 3'b111, 3'b000, 1'b0, 3'b000};

    tick(2);
    checkOutput("reset soft_reset", {5'b0, softReset}, 8'h00);
    resetn = 1'b1;
    monEn  = 1'b1;
    tick(1);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("vec%0d write_enb", i), {5'b0, writeEnb}, {5'b0, vecs[i].expWe});
      checkOutput($sformatf("vec%0d fifo_full", i), {7'b0, fifoFull}, {7'b0, vecs[i].expFf});
      checkOutput($sformatf("vec%0d vld_out", i), {5'b0, vldOut}, {5'b0, vecs[i].expVld});
      tick(1);
    end
    detectAdd   = 1'b0;
    writeEnbReg = 1'b0;
    emptyIn     = 3'b111;
    tick(2);

    // Port 0 held unread: pulse on the 30th edge.
    emptyIn[0] = 1'b0;
    k = cyc;
    expectPulse(k + 30, 3'b001);
    tick(30);
    emptyIn[0] = 1'b1;
    tick(3);

    // Read on the 29th edge restarts the window.
    emptyIn[0] = 1'b0;
    k = cyc;
    tick(28);
    readEnb[0] = 1'b1;
    tick(1);
    readEnb[0] = 1'b0;
    expectPulse(k + 59, 3'b001);
    tick(30);
    emptyIn[0] = 1'b1;
    tick(3);

    // Ports 1 and 2 time out together.
    emptyIn = 3'b001;
    k = cyc;
    expectPulse(k + 30, 3'b110);
    tick(30);
    emptyIn = 3'b111;
    tick(3);
`ifdef ROUTER_SYNC_DROP_CNT_EN
    checkOutput("drop_count", dropCount, 8'(dropExp));
`endif

    // Reset on edge 20 of a pending timeout discards the partial count.
    emptyIn[0] = 1'b0;
    k = cyc;
    tick(19);
    resetn = 1'b0;
    tick(1);
    resetn  = 1'b1;
    dropExp = 0;
    writeEnbReg = 1'b1;
    #1;
    checkOutput("post-reset write_enb", {5'b0, writeEnb}, 8'h00);
    checkOutput("post-reset fifo_full", {7'b0, fifoFull}, 8'h00);
    writeEnbReg = 1'b0;
    expectPulse(k + 50, 3'b001);
    tick(30);
    emptyIn[0] = 1'b1;
    tick(3);
`ifdef ROUTER_SYNC_DROP_CNT_EN
    checkOutput("drop_count after reset", dropCount, 8'(dropExp));
`endif

    monEn = 1'b0;
    if (sbQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL pending pulses: got %0d outstanding expected 0", sbQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
